approx_adder_eval_ctrl: RTL and testbench

- Sequencer that drives operand pairs into an external approximate adder under test.
- Computes the exact sum internally, compares it with the adder's output, and accumulates error statistics: mismatch count, sum of absolute error, maximum absolute error.
- Sits between a host/config interface and one combinational approximate-adder netlist (two W-bit operands, OW-bit sum).

---
 rtl/adder_eval_pkg.sv | 26 ++
 rtl/eval_lfsr32.sv | 25 ++
 rtl/approx_adder_eval_ctrl.sv | 171 +++++++++++++++++
 tb/tb_approx_adder_eval_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_eval_pkg.sv
// Shared types and constants for the approximate-adder error-evaluation controllers.
// Holds the controller state encoding, pair-generator modes and the LFSR polynomial.
package adder_eval_pkg;

  localparam int DEF_W  = 16;
  localparam int DEF_OW = 17;
  localparam int DEF_CW = 32;

  // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_LFSR  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } eval_state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'd0);
  endfunction

endpackage

// File: rtl/eval_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and advance enable.
// A zero seed would lock the register at zero, so it is replaced by 1 on load.
module eval_lfsr32
  import adder_eval_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 32'd1;
    end else if (load) begin
      state <= (seed == 32'd0) ? 32'd1 : seed;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/approx_adder_eval_ctrl.sv
// Drives operand pairs into an external approximate adder, compares its sum with the
// exact sum one cycle later and accumulates mismatch count, total and maximum |error|.
module approx_adder_eval_ctrl
  import adder_eval_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int OW = DEF_OW,
  parameter int CW = DEF_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [31:0]      seed,
  input  logic [CW-1:0]    n_samples,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [OW-1:0]    dut_sum,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    err_cnt,
  output logic [OW+CW-1:0] sum_abs_err,
  output logic [OW-1:0]    max_abs_err,
  output logic [CW-1:0]    sample_cnt
);

  eval_state_t state, state_nxt;

  logic          accept;
  logic          issue;
  logic          compare;
  logic          mode_q;
  logic          cmp_v;
  logic [31:0]   cnt_gen;
  logic [31:0]   lfsr_state;
  logic [31:0]   gen;
  logic [CW-1:0] remaining;

  logic [OW-1:0]        exact;
  logic signed [OW:0]   diff;
  logic signed [OW:0]   diff_abs;
  logic [OW-1:0]        abs_err;

  eval_lfsr32 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .seed    (seed),
    .advance (issue),
    .state   (lfsr_state)
  );

  assign gen = (mode_q == MODE_LFSR) ? lfsr_state : cnt_gen;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort has priority over everything while busy.
  // NOTE: default assignment first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = (n_samples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (remaining == CW'(1)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_nxt = abort ? ST_IDLE : ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    issue   = 1'b0;
    compare = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = start;
      end
      ST_RUN: begin
        busy    = 1'b1;
        issue   = !abort;
        compare = cmp_v;
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        compare = cmp_v;
      end
      ST_DONE: begin
        done   = 1'b1;
        accept = start;
      end
      default: ;
    endcase
  end

  // The operand registers hold the pair under test for a full cycle, so they double
  // as the delayed copies from which the exact reference sum is formed.
  always_comb begin
    exact    = OW'(op_a) + OW'(op_b);
    diff     = $signed({1'b0, exact}) - $signed({1'b0, dut_sum});
    diff_abs = diff[OW] ? -diff : diff;
    abs_err  = diff_abs[OW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_COUNT;
      cnt_gen     <= '0;
      remaining   <= '0;
      cmp_v       <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      sample_cnt  <= '0;
    end else begin
      cmp_v <= issue;

      if (accept) begin
        mode_q      <= mode;
        cnt_gen     <= seed;
        remaining   <= n_samples;
        err_cnt     <= '0;
        sum_abs_err <= '0;
        max_abs_err <= '0;
        sample_cnt  <= '0;
      end

      if (issue) begin
        op_a      <= gen[W-1:0];
        op_b      <= gen[2*W-1:W];
        cnt_gen   <= cnt_gen + 32'd1;
        remaining <= remaining - CW'(1);
      end

      if (compare) begin
        sample_cnt  <= sample_cnt + CW'(1);
        sum_abs_err <= sum_abs_err + (OW+CW)'(abs_err);
        if (abs_err != '0) begin
          err_cnt <= err_cnt + CW'(1);
        end
        if (abs_err > max_abs_err) begin
          max_abs_err <= abs_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_adder_eval_ctrl.sv
// Bench for approx_adder_eval_ctrl: a behavioural adder-under-test model drives dut_sum,
// and expected pairs/statistics come from a plain-arithmetic reference model.
module tb_approx_adder_eval_ctrl;

  localparam int W  = 16;
  localparam int OW = 17;
  localparam int CW = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             mode = 1'b0;
  logic [31:0]      seed = '0;
  logic [CW-1:0]    n_samples = '0;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [OW-1:0]    dut_sum;
  logic             busy;
  logic             done;
  logic [CW-1:0]    err_cnt;
  logic [OW+CW-1:0] sum_abs_err;
  logic [OW-1:0]    max_abs_err;
  logic [CW-1:0]    sample_cnt;

  int model_sel = 0;
  int n_vec = 0;
  int n_fail = 0;

  approx_adder_eval_ctrl #(.W(W), .OW(OW), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .seed        (seed),
    .n_samples   (n_samples),
    .op_a        (op_a),
    .op_b        (op_b),
    .dut_sum     (dut_sum),
    .busy        (busy),
    .done        (done),
    .err_cnt     (err_cnt),
    .sum_abs_err (sum_abs_err),
    .max_abs_err (max_abs_err),
    .sample_cnt  (sample_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Adder-under-test models: 0 exact, 1 LSB stuck-at-0, 2 carry-out dropped,
  // 3 lower-part-OR adder (low 4 bits OR'ed, upper bits added exactly).
  function automatic logic [OW-1:0] approx(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [OW-1:0] ex;
    logic [OW-1:0] r;
    ex = OW'(a) + OW'(b);
    case (m)
      1: begin r = ex; r[0] = 1'b0; end
      2: r = OW'(ex[W-1:0]);
      3: r = ((OW'(a[W-1:4]) + OW'(b[W-1:4])) << 4) | OW'(a[3:0] | b[3:0]);
      default: r = ex;
    endcase
    return r;
  endfunction

  always_comb dut_sum = approx(model_sel, op_a, op_b);

  // Galois LFSR for x^32 + x^22 + x^2 + x + 1, shifting toward the LSB.
  function automatic logic [31:0] lfsr_next(input logic [31:0] g);
    logic fb;
    fb = g[0];
    g = g >> 1;
    if (fb) g = g ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
    return g;
  endfunction

  function automatic logic [31:0] first_gen(input bit m, input logic [31:0] sd);
    return (m && sd == 32'd0) ? 32'd1 : sd;
  endfunction

  function automatic logic [31:0] step_gen(input bit m, input logic [31:0] g);
    return m ? lfsr_next(g) : g + 32'd1;
  endfunction

  task automatic ref_model(input bit m, input logic [31:0] sd, input logic [31:0] n, input int model,
                           output logic [63:0] e_err, output logic [63:0] e_sum,
                           output logic [63:0] e_max, output logic [63:0] e_cnt);
    logic [31:0] g;
    longint ex, ap, ae;
    g = first_gen(m, sd);
    e_err = 0; e_sum = 0; e_max = 0; e_cnt = 0;
    for (int i = 0; i < int'(n); i++) begin
      ex = longint'(g[15:0]) + longint'(g[31:16]);
      ap = longint'(approx(model, g[15:0], g[31:16]));
      ae = (ex > ap) ? ex - ap : ap - ex;
      if (ae != 0) e_err++;
      e_sum += 64'(ae);
      if (64'(ae) > e_max) e_max = 64'(ae);
      e_cnt++;
      g = step_gen(m, g);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Runs one evaluation from IDLE/DONE; called just after a falling edge.
  task automatic do_run(input string name, input bit m, input logic [31:0] sd, input logic [31:0] n,
                        input int model, input logic [63:0] e_err, input logic [63:0] e_sum,
                        input logic [63:0] e_max, input logic [63:0] e_cnt);
    logic [31:0] pairs[$];
    logic [31:0] g;
    logic [W-1:0] a0, b0;
    g = first_gen(m, sd);
    for (int i = 0; i < int'(n); i++) begin
      pairs.push_back(g);
      g = step_gen(m, g);
    end
    model_sel = model; mode = m; seed = sd; n_samples = n;
    a0 = op_a; b0 = op_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      check({name, " pair"}, 64'({op_b, op_a}), 64'(pairs[i]));
      if (i == 0 || i == int'(n) - 1) check({name, " busy"}, 64'(busy), 64'd1);
    end
    if (n != 0) @(negedge clk);
    check({name, " done"}, 64'(done), 64'd1);
    check({name, " busy_end"}, 64'(busy), 64'd0);
    check({name, " err_cnt"}, 64'(err_cnt), e_err);
    check({name, " sum_abs_err"}, 64'(sum_abs_err), e_sum);
    check({name, " max_abs_err"}, 64'(max_abs_err), e_max);
    check({name, " sample_cnt"}, 64'(sample_cnt), e_cnt);
    if (n == 0) check({name, " ops_held"}, 64'({op_b, op_a}), 64'({b0, a0}));
  endtask

  typedef struct {
    string       name;
    bit          m;
    logic [31:0] sd;
    logic [31:0] n;
    int          model;
    logic [63:0] e_err;
    logic [63:0] e_sum;
    logic [63:0] e_max;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [63:0] r_err, r_sum, r_max, r_cnt;
    logic [CW-1:0] frozen;

    tbl[0] = '{"exact_1000", 1'b0, 32'h0000_0000, 32'd1000, 0, 64'd0, 64'd0, 64'd0, 64'd1000};
    tbl[1] = '{"lsb_stuck", 1'b0, 32'h0000_0000, 32'd4, 1, 64'd2, 64'd2, 64'd1, 64'd4};
    tbl[2] = '{"carry_drop", 1'b0, 32'hFFFF_FFFF, 32'd2, 2, 64'd1, 64'd65536, 64'd65536, 64'd2};
    tbl[3] = '{"n_zero", 1'b0, 32'h1234_5678, 32'd0, 1, 64'd0, 64'd0, 64'd0, 64'd0};
    tbl[4] = '{"lfsr_seed0", 1'b1, 32'h0000_0000, 32'd3, 0, 64'd0, 64'd0, 64'd0, 64'd3};

    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset ops", 64'({op_b, op_a}), 64'd0);
    check("reset stats", 64'(err_cnt) | 64'(sum_abs_err) | 64'(max_abs_err) | 64'(sample_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      do_run(tbl[i].name, tbl[i].m, tbl[i].sd, tbl[i].n, tbl[i].model,
             tbl[i].e_err, tbl[i].e_sum, tbl[i].e_max, tbl[i].e_cnt);

    // Abort in cycle 5 together with a start: abort wins, compare in that cycle counts.
    model_sel = 1; mode = 1'b0; seed = 32'd0; n_samples = 32'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort sample_cnt", 64'(sample_cnt), 64'd4);
    check("abort err_cnt", 64'(err_cnt), 64'd2);
    check("abort sum_abs_err", 64'(sum_abs_err), 64'd2);
    check("abort max_abs_err", 64'(max_abs_err), 64'd1);
    frozen = sample_cnt;
    repeat (3) @(negedge clk);
    check("abort frozen", 64'(sample_cnt), 64'(frozen));
    check("abort idle busy", 64'(busy), 64'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle abort busy", 64'(busy), 64'd0);
    check("idle abort done", 64'(done), 64'd0);
    do_run("restart", 1'b0, 32'd0, 32'd4, 1, 64'd2, 64'd2, 64'd1, 64'd4);

    // A start pulse while busy must not restart or reshape the run.
    model_sel = 0; mode = 1'b0; seed = 32'd100; n_samples = 32'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_samples = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_start still busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy_start done", 64'(done), 64'd1);
    check("busy_start sample_cnt", 64'(sample_cnt), 64'd6);

    // Randomized runs against the reference model.
    for (int r = 0; r < 8; r++) begin
      bit m;
      logic [31:0] sd, n;
      int model;
      m = 1'($urandom_range(0, 1));
      sd = $urandom;
      if (r == 0) sd = 32'd0;
      n = 32'($urandom_range(1, 40));
      model = $urandom_range(1, 3);
      ref_model(m, sd, n, model, r_err, r_sum, r_max, r_cnt);
      do_run($sformatf("rand%0d", r), m, sd, n, model, r_err, r_sum, r_max, r_cnt);
    end

    // Reset in the middle of a run returns everything to zero at once.
    model_sel = 3; mode = 1'b1; seed = 32'hACE1_1234; n_samples = 32'd50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset ops", 64'({op_b, op_a}), 64'd0);
    check("midreset stats", 64'(err_cnt) | 64'(sum_abs_err) | 64'(max_abs_err) | 64'(sample_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset no done", 64'(done), 64'd0);
    check("midreset no busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
